// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - relation encodings and helpers for the branch comparison pipeline
package cmp_pkg;

  localparam int CMP_OP_W = 4;

  typedef enum logic [CMP_OP_W-1:0] {
    CMP_EQ  = 4'd0,
    CMP_NE  = 4'd1,
    CMP_LT  = 4'd2,
    CMP_LE  = 4'd3,
    CMP_GT  = 4'd4,
    CMP_GE  = 4'd5,
    CMP_LTU = 4'd6,
    CMP_LEU = 4'd7,
    CMP_GTU = 4'd8,
    CMP_GEU = 4'd9
  } cmp_op_e;

  function automatic logic is_defined_op(input logic [CMP_OP_W-1:0] op);
    return op <= CMP_GEU;
  endfunction

endpackage

// File: rtl/cmp_pipe_stage.sv
// rtl/cmp_pipe_stage.sv - one valid/payload register slice with upstream ready
module cmp_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn_i,
  input  logic         flush_i,
  input  logic         up_valid_i,
  output logic         up_ready_o,
  input  logic [W-1:0] up_data_i,
  output logic         dn_valid_o,
  input  logic         dn_ready_i,
  output logic [W-1:0] dn_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign up_ready_o = !valid_q || dn_ready_i;
  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;

  // Payload only loads on a real accept so it stays stable under backpressure.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (up_ready_o) valid_d = up_valid_i;
    if (up_valid_i && up_ready_o) data_d = up_data_i;
    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/branch_compare_pipe.sv
// rtl/branch_compare_pipe.sv - pipelined RISC-V branch/SLT comparator with tag, flush and taken counter
module branch_compare_pipe
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STAGES      = 2,
  parameter int TAG_WIDTH   = 5,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  inputA,
  input  logic [DATA_WIDTH-1:0]  inputB,
  input  logic [CMP_OP_W-1:0]    compSelect,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  compOut,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_err,
  output logic [COUNT_WIDTH-1:0] taken_count
);

  localparam int PW = TAG_WIDTH + 2;

  logic [DATA_WIDTH-1:0] a_s, b_s;
  logic                  eq, lt_u, lt_s, res, err;
  logic                  stg_valid [STAGES+1];
  logic                  stg_ready [STAGES+1];
  logic [PW-1:0]         stg_data  [STAGES+1];
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                  xfer;

  // Flipping the MSBs maps two's complement order onto unsigned order.
  assign a_s  = {~inputA[DATA_WIDTH-1], inputA[DATA_WIDTH-2:0]};
  assign b_s  = {~inputB[DATA_WIDTH-1], inputB[DATA_WIDTH-2:0]};
  assign eq   = inputA == inputB;
  assign lt_u = inputA < inputB;
  assign lt_s = a_s < b_s;
  assign err  = !is_defined_op(compSelect);

  always_comb begin
    res = 1'b0;
    case (compSelect)
      CMP_EQ:  res = eq;
      CMP_NE:  res = !eq;
      CMP_LT:  res = lt_s;
      CMP_LE:  res = lt_s || eq;
      CMP_GT:  res = !(lt_s || eq);
      CMP_GE:  res = !lt_s;
      CMP_LTU: res = lt_u;
      CMP_LEU: res = lt_u || eq;
      CMP_GTU: res = !(lt_u || eq);
      CMP_GEU: res = !lt_u;
      default: res = 1'b0;
    endcase
  end

  assign stg_valid[0]      = in_valid && in_ready;
  assign stg_data[0]       = {in_tag, err, res};
  assign stg_ready[STAGES] = out_ready;
  assign in_ready          = reset && !flush && stg_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cmp_pipe_stage #(.W(PW)) u_stage (
      .clk        (clk),
      .resetn_i   (reset),
      .flush_i    (flush),
      .up_valid_i (stg_valid[k]),
      .up_ready_o (stg_ready[k]),
      .up_data_i  (stg_data[k]),
      .dn_valid_o (stg_valid[k+1]),
      .dn_ready_i (stg_ready[k+1]),
      .dn_data_o  (stg_data[k+1])
    );
  end

  assign out_valid = stg_valid[STAGES];
  assign out_tag   = stg_data[STAGES][PW-1:2];
  assign out_err   = stg_data[STAGES][1];
  assign compOut   = {{(DATA_WIDTH-1){1'b0}}, stg_data[STAGES][0]};
  assign xfer      = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (xfer && stg_data[STAGES][0] && !out_err && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign taken_count = count_q;

endmodule

// File: tb/tb_branch_compare_pipe.sv
// tb/tb_branch_compare_pipe.sv - scoreboard and vector-table bench for branch_compare_pipe
module tb_branch_compare_pipe;

  localparam int DW = 32;
  localparam int ST = 2;
  localparam int TW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid, out_err;
  logic [DW-1:0] inputA, inputB, compOut;
  logic [3:0]    compSelect;
  logic [TW-1:0] in_tag, out_tag;
  logic [CW-1:0] taken_count;

  always #5 clk = ~clk;

  branch_compare_pipe #(
    .DATA_WIDTH(DW), .STAGES(ST), .TAG_WIDTH(TW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inputA(inputA), .inputB(inputB), .compSelect(compSelect), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .compOut(compOut), .out_tag(out_tag), .out_err(out_err),
    .taken_count(taken_count)
  );

  typedef struct {
    logic          res;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    op;
    logic          res;
    logic          err;
  } vec_t;

  exp_t    sb[$];
  int      vectors = 0;
  int      miscompares = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic    stalled = 1'b0;
  logic [DW+TW:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [3:0] op);
    case (op)
      4'd0: return {1'b0, a == b};
      4'd1: return {1'b0, a != b};
      4'd2: return {1'b0, $signed(a) <  $signed(b)};
      4'd3: return {1'b0, $signed(a) <= $signed(b)};
      4'd4: return {1'b0, $signed(a) >  $signed(b)};
      4'd5: return {1'b0, $signed(a) >= $signed(b)};
      4'd6: return {1'b0, a <  b};
      4'd7: return {1'b0, a <= b};
      4'd8: return {1'b0, a >  b};
      4'd9: return {1'b0, a >= b};
      default: return 2'b10;
    endcase
  endfunction

  // Output monitor: pops the scoreboard on each transfer and tracks the expected counter.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      exp_cnt = '0;
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) chk("payload_stable", {compOut, out_tag, out_err}, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {out_tag, out_err, compOut[0]}, 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {compOut, out_tag, out_err}, {{(DW-1){1'b0}}, e.res, e.tag, e.err});
          chk("count_at_xfer", taken_count, exp_cnt);
          if (e.res && !e.err && exp_cnt != 4'hF) exp_cnt = exp_cnt + 1'b1;
        end
      end
      stalled = out_valid && !out_ready;
      held = {compOut, out_tag, out_err};
      if (flush) sb.delete();
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op,
                      input logic [TW-1:0] tag);
    logic [1:0] m;
    logic ok;
    m = model(a, b, op);
    inputA = a; inputB = b; compSelect = op; in_tag = tag; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{res: m[0], tag: tag, err: m[1]});
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  vec_t tbl[$];
  int   n;
  int   acc;
  logic [CW-1:0] saved;

  initial begin
    tbl = '{
      '{32'h8000_0000, 32'h0000_0001, 4'd2, 1'b1, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd6, 1'b0, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd5, 1'b0, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd9, 1'b1, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd4, 1'b0, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd8, 1'b1, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd3, 1'b1, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd7, 1'b0, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd0, 1'b0, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 4'd1, 1'b1, 1'b0},
      '{32'h0000_0005, 32'h0000_0005, 4'd3, 1'b1, 1'b0},
      '{32'h0000_0005, 32'h0000_0005, 4'd2, 1'b0, 1'b0},
      '{32'h0000_0005, 32'h0000_0005, 4'd8, 1'b0, 1'b0},
      '{32'hFFFF_FFFF, 32'h0000_0000, 4'd2, 1'b1, 1'b0},
      '{32'hFFFF_FFFF, 32'h0000_0000, 4'd6, 1'b0, 1'b0},
      '{32'h0000_0003, 32'h0000_0009, 4'hF, 1'b0, 1'b1}
    };

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inputA = '0; inputB = '0; compSelect = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out", {out_valid, compOut, out_tag, out_err, taken_count}, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Latency: accept edge counts as the first edge.
    send(32'd8, 32'd8, 4'd0, 5'd17);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency_edges", n, ST);
    drain();
    chk("count_after_eq", taken_count, 1);

    saved = taken_count;
    send(32'd7, 32'd7, 4'hC, 5'd3);
    drain();
    chk("count_after_err", taken_count, saved);

    // Table: check the bench model matches the table, then stream back-to-back.
    foreach (tbl[i]) chk($sformatf("model_%0d", i), model(tbl[i].a, tbl[i].b, tbl[i].op),
                         {tbl[i].err, tbl[i].res});
    foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].op, TW'(i));
    drain();

    // Backpressure: only STAGES items fit while out_ready is low.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      inputA = 32'(acc); inputB = 32'd3; compSelect = 4'd6; in_tag = TW'(20 + acc);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{res: model(32'(acc), 32'd3, 4'd6) & 2'b01, tag: TW'(20 + acc), err: 1'b0});
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, ST);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    for (int i = acc; i < 8; i++) send(32'(i), 32'd3, 4'd6, TW'(20 + i));
    drain();

    // Flush with two items in flight and a new input offered.
    out_ready = 1'b0;
    send(32'd1, 32'd1, 4'd0, 5'd10);
    send(32'd2, 32'd2, 4'd0, 5'd11);
    saved = taken_count;
    inputA = 32'd4; inputB = 32'd4; compSelect = 4'd0; in_tag = 5'd12;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_stays_empty", out_valid, 0);
    chk("flush_count_kept", taken_count, saved);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) send(32'(i), 32'(i), 4'd0, TW'(i));
    drain();
    chk("count_saturated", taken_count, 4'hF);

    // Reset in the middle of a stream.
    out_ready = 1'b0;
    send(32'd1, 32'd2, 4'd6, 5'd1);
    send(32'd1, 32'd2, 4'd6, 5'd2);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out", {out_valid, compOut, out_tag, out_err, taken_count}, 0);
    chk("midrst_in_ready", in_ready, 0);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_compare_pipe.md
# branch_compare_pipe

Parametrised, pipelined successor of the single-cycle comparison unit. Evaluates all RISC-V branch/SLT relations, signed and unsigned, on DATA_WIDTH operands, carries a tag alongside the result through STAGES registered stages with valid/ready backpressure and a flush, and keeps a saturating count of true results. It sits between the register-read stage and branch resolution / SLT writeback.

## Interface
- DATA_WIDTH, 32: operand width, ≥2.
- STAGES, 2: pipeline depth, 1–4.
- TAG_WIDTH, 5: sideband tag width (e.g. rd or ROB index), ≥1.
- COUNT_WIDTH, 16: true-result counter width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  operands/op present.
- in_ready  out  1  stage 0 can accept.
- inputA  in  DATA_WIDTH  left operand.
- inputB  in  DATA_WIDTH  right operand.
- compSelect  in  4  relation, cmp_op_e.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result present at last stage.
- out_ready  in  1  consumer accepts.
- compOut  out  DATA_WIDTH  result, zero-extended in bit 0.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_err  out  1  compSelect was an undefined code.
- taken_count  out  COUNT_WIDTH  saturating count of delivered true results.

## Operation
- Encodings: EQ=0, NE=1, LT=2, LE=3, GT=4, GE=5 (two's complement); LTU=6, LEU=7, GTU=8, GEU=9 (unsigned); 10–15 undefined → compOut=0, out_err=1.
- Signed compare: invert MSB of both operands, then unsigned compare; no subtraction overflow path.
- Relation evaluated combinationally on input; result bit, err and tag are captured into stage 0 on accept (in_valid && in_ready).
- Stage k advances when stage k+1 is empty or advancing; last stage advances on out_ready. Bubbles collapse; no global stall.
- in_ready = !flush && (stage 0 empty || stage 0 advancing).
- Transfer out = out_valid && out_ready. On transfer with compOut[0]=1 and out_err=0, taken_count += 1, saturating at all-ones.
- flush: clears every stage valid next edge; input in same cycle dropped (in_ready low); transfer on output in the flush cycle still completes and counts; taken_count not cleared.
- reset (low): all valids 0, taken_count 0; overrides flush and in_valid.

## Timing
- Reset values: in_ready 0 during reset, 1 the cycle after; out_valid 0; compOut 0; out_tag 0; out_err 0; taken_count 0.
- Latency: accept at edge N → out_valid high after edge N+STAGES−1 (visible cycle N+STAGES−1 relative to accept edge, i.e. STAGES edges including accept), given no backpressure.
- Throughput 1 per cycle with out_ready held high.
- Payload (compOut, out_tag, out_err) stable while out_valid && !out_ready.
- With out_ready low, pipeline fills: in_ready falls after STAGES accepts; accepts exactly STAGES items, none lost.
- Simultaneous accept and transfer on a full pipeline sustained (in_ready high when last stage advancing).

## Structure
- cmp_pkg: cmp_op_e enum (10 codes), CMP_OP_W=4, helper function is_defined_op.
- Sub-module cmp_pipe_stage: one valid/payload register with upstream ready generation, parametrised by payload width; instantiated STAGES times via generate.
- Top holds compare logic, counter, flush fan-out.

## Test plan
- Reset then EQ, A=8, B=8, STAGES=2, out_ready=1 → compOut=1, out_tag=in_tag, out_valid exactly 2 edges after accept; taken_count=1.
- LT vs LTU, A=32'h8000_0000, B=32'h0000_0001 → LT gives 1, LTU gives 0; GE gives 0, GEU gives 1.
- Back-to-back 8 ops, out_ready=0 for 5 cycles → in_ready drops after 2 accepts, results emerge in order with correct tags, none dropped or duplicated.
- compSelect=4'hC, A=B=7 → compOut=0, out_err=1, taken_count unchanged.
- flush with 2 items in flight and in_valid=1 → both cleared, new input dropped, out_valid 0 next cycle, taken_count kept.
- COUNT_WIDTH=4, 20 true results → taken_count saturates at 4'hF; reset mid-stream → all outputs return to reset values next edge.
